// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared types and defaults for the memory port controller.
//   mem_state_e - controller states (IDLE, RD_WAIT, MERGE)
//   ADDR_W_DEF / DATA_W_DEF - default word-address and data widths
//   RD_LAT_MAX - largest supported BRAM read latency
package mem_port_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 32;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        MERGE
    } mem_state_e;

endpackage

// File: rtl/mem_byte_merge.sv
// mem_byte_merge: per-byte select of new data over old data under a byte mask.
//   new_i  - replacement data
//   old_i  - current memory word
//   be_i   - byte mask, 1 selects the byte from new_i
//   data_o - merged word
module mem_byte_merge
    import mem_port_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]   new_i,
    input  logic [DATA_W-1:0]   old_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   data_o
);

    for (genvar i = 0; i < DATA_W/8; i++) begin : g_byte
        assign data_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: valid/ready memory port between the core load/store unit and a single-port BRAM.
//   clk, rstn                      - clock, asynchronous active-low reset
//   req_valid/req_ready            - request handshake (ready only in IDLE)
//   req_we/req_addr/req_be/req_wdata - store flag, byte address, byte enables, store data
//   rsp_valid/rsp_rdata/rsp_err    - one-cycle response pulse, load data, out-of-range flag
//   mem_addr/mem_we/mem_din/mem_dout - BRAM word address, write enables, write data, read data
// Optional feature: MEM_BYTE_WE_EN - BRAM has per-byte write enables, so partial stores
// write directly instead of using a read-modify-write sequence.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [DATA_W-1:0]   mem_din,
    input  logic [DATA_W-1:0]   mem_dout
);

    localparam int BE_W  = DATA_W/8;
    localparam int OFS_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(RD_LAT+1);

    mem_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic               accept;
    logic               oor;
    logic               go_rd;
    logic [ADDR_W-1:0]  word_addr;
    logic               unused_ofs;

    assign accept      = req_valid && req_ready;
    assign word_addr   = req_addr[OFS_W +: ADDR_W];
    assign oor         = (req_addr >> (OFS_W + ADDR_W)) != 0;
    assign unused_ofs  = ^(req_addr & 32'(BE_W-1));
    assign req_ready   = state_q == IDLE;
    assign mem_addr    = accept ? word_addr : addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

`ifdef MEM_BYTE_WE_EN
    assign go_rd   = accept && !oor && !req_we;
    assign mem_we  = (accept && req_we && !oor) ? req_be : '0;
    assign mem_din = accept ? req_wdata : wdata_q;
`else
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] merged;
    logic              we_q;
    logic              full;

    assign full = &req_be;
    // Loads and partial stores both need the old word; zero-mask stores need nothing.
    assign go_rd   = accept && !oor && (!req_we || (|req_be && !full));
    // Single-enable BRAM: every bit carries the same write strobe.
    assign mem_we  = {BE_W{(accept && req_we && !oor && full) || state_q == MERGE}};
    assign mem_din = accept ? req_wdata : merged;

    mem_byte_merge #(.DATA_W(DATA_W)) u_merge (
        .new_i  (wdata_q),
        .old_i  (old_q),
        .be_i   (be_q),
        .data_o (merged)
    );
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifndef MEM_BYTE_WE_EN
            be_q        <= '0;
            old_q       <= '0;
            we_q        <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    addr_q  <= word_addr;
                    wdata_q <= req_wdata;
                    cnt_q   <= CNT_W'(1);
`ifndef MEM_BYTE_WE_EN
                    be_q    <= req_be;
                    we_q    <= req_we;
`endif
                    if (go_rd) begin
                        state_q <= RD_WAIT;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= oor;
                        rsp_rdata_q <= '0;
                    end
                end
                RD_WAIT: if (cnt_q == CNT_W'(RD_LAT)) begin
`ifndef MEM_BYTE_WE_EN
                    if (we_q) begin
                        old_q   <= mem_dout;
                        state_q <= MERGE;
                    end else begin
`endif
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= mem_dout;
                        state_q     <= IDLE;
`ifndef MEM_BYTE_WE_EN
                    end
`endif
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
`ifndef MEM_BYTE_WE_EN
                MERGE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                    state_q     <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
